// File: rtl/f1_reaction_timer_if.sv
// Handshake bundle between the start-light sequencer, ms tick source and
// the reaction timer; master drives the stimuli, slave returns the results.
interface f1_reaction_timer_if #(
  parameter int REACT_W = 12
);
  logic               tick;
  logic               cmd_delay;
  logic               button;
  logic               time_out;
  logic               false_start;
  logic               react_valid;
  logic [REACT_W-1:0] react_ms;
  logic               busy;

  modport master (
    output tick, cmd_delay, button,
    input  time_out, false_start, react_valid, react_ms, busy
  );

  modport slave (
    input  tick, cmd_delay, button,
    output time_out, false_start, react_valid, react_ms, busy
  );
endinterface

// File: rtl/f1_reaction_timer.sv
// Random hold after all lights lit, then measures driver reaction in ms.
// Free-running 7-bit LFSR picks the hold length (1..127 ticks).
module f1_reaction_timer #(
  parameter int REACT_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  f1_reaction_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, REACT} state_t;

  localparam logic [REACT_W-1:0] REACT_MAX = '1;

  state_t             state, state_nxt;
  logic [6:0]         lfsr;
  logic [6:0]         hold_cnt, hold_nxt;
  logic [REACT_W-1:0] react_cnt, react_nxt;
  logic [REACT_W-1:0] ms_q, ms_nxt;
  logic               btn_q, btn_rise;
  logic               to_q, to_nxt;
  logic               fs_q, fs_nxt;
  logic               rv_q, rv_nxt;

  assign btn_rise = bus.button & ~btn_q;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    react_nxt = react_cnt;
    ms_nxt    = ms_q;
    to_nxt    = 1'b0;
    fs_nxt    = 1'b0;
    rv_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_delay) begin
          hold_nxt  = lfsr;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A press beats the final tick: a jump start is never forgiven.
        if (btn_rise) begin
          fs_nxt    = 1'b1;
          state_nxt = IDLE;
        end else if (bus.tick) begin
          if (hold_cnt == 7'd1) begin
            to_nxt    = 1'b1;
            react_nxt = '0;
            state_nxt = REACT;
          end else begin
            hold_nxt = hold_cnt - 7'd1;
          end
        end
      end
      REACT: begin
        if (btn_rise) begin
          ms_nxt    = react_cnt;
          rv_nxt    = 1'b1;
          state_nxt = IDLE;
        end else if (bus.tick) begin
          if (react_cnt == REACT_MAX) begin
            ms_nxt    = REACT_MAX;
            rv_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            react_nxt = react_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= 7'h01;
      btn_q     <= 1'b0;
      hold_cnt  <= '0;
      react_cnt <= '0;
      ms_q      <= '0;
      to_q      <= 1'b0;
      fs_q      <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      btn_q     <= bus.button;
      hold_cnt  <= hold_nxt;
      react_cnt <= react_nxt;
      ms_q      <= ms_nxt;
      to_q      <= to_nxt;
      fs_q      <= fs_nxt;
      rv_q      <= rv_nxt;
    end
  end

  assign bus.time_out    = to_q;
  assign bus.false_start = fs_q;
  assign bus.react_valid = rv_q;
  assign bus.react_ms    = ms_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer: scenario table, corner sequences and random
// traffic, all checked cycle by cycle against an event-level reference.
module tb_f1_reaction_timer;
  localparam int RW   = 12;
  localparam int RMAX = (1 << RW) - 1;
  localparam int M_IDLE = 0, M_HOLD = 1, M_REACT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  f1_reaction_timer_if #(.REACT_W(RW)) bus ();
  f1_reaction_timer #(.REACT_W(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: pseudo-random value sequence indexed by cycles since reset.
  int seq [127];
  int m_idx, m_mode, m_target, m_seen, m_elapsed, m_ms;
  bit m_prev, m_to, m_fs, m_rv;

  typedef struct {
    int pre;       // idle cycles between reset and cmd_delay
    int hold;      // expected hold length in ticks
    int react;     // ticks during REACT before the press
    int exp_ms;    // expected react_ms
  } scen_t;

  scen_t scen [4];

  function automatic void build_seq();
    int v = 1;
    for (int i = 0; i < 127; i++) begin
      seq[i] = v;
      v = ((v << 1) & 'h7f) | (((v >> 6) ^ (v >> 5)) & 1);
    end
  endfunction

  function void model(bit r, bit t, bit c, bit b);
    bit rise;
    m_to = 0; m_fs = 0; m_rv = 0;
    if (r) begin
      m_mode = M_IDLE; m_idx = 0; m_prev = 0; m_ms = 0;
      return;
    end
    rise = b && !m_prev;
    case (m_mode)
      M_IDLE: if (c) begin m_target = seq[m_idx]; m_seen = 0; m_mode = M_HOLD; end
      M_HOLD: begin
        if (rise) begin m_fs = 1; m_mode = M_IDLE; end
        else if (t) begin
          m_seen++;
          if (m_seen == m_target) begin m_to = 1; m_elapsed = 0; m_mode = M_REACT; end
        end
      end
      default: begin
        if (rise) begin m_ms = m_elapsed; m_rv = 1; m_mode = M_IDLE; end
        else if (t) begin
          if (m_elapsed == RMAX) begin m_ms = RMAX; m_rv = 1; m_mode = M_IDLE; end
          else m_elapsed++;
        end
      end
    endcase
    m_prev = b;
    m_idx  = (m_idx + 1) % 127;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit t, input bit c, input bit b);
    logic [RW+3:0] act, exp;
    rst = r; bus.tick = t; bus.cmd_delay = c; bus.button = b;
    model(r, t, c, b);
    @(posedge clk);
    #1;
    act = {bus.time_out, bus.false_start, bus.react_valid, bus.busy, bus.react_ms};
    exp = {m_to, m_fs, m_rv, (m_mode != M_IDLE), m_ms[RW-1:0]};
    chk("outputs_vs_model", int'(act), int'(exp));
  endtask

  task automatic run_scen(input scen_t s);
    step(1, 0, 0, 0);
    repeat (s.pre) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("busy_after_cmd", bus.busy, 1);
    for (int k = 0; k < s.hold - 1; k++) begin
      step(0, 1, 0, 0);
      chk("no_early_time_out", bus.time_out, 0);
      step(0, 0, 0, 0);
    end
    step(0, 1, 0, 0);
    chk("time_out", bus.time_out, 1);
    repeat (s.react) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
    step(0, 0, 0, 1);
    chk("react_valid", bus.react_valid, 1);
    chk("react_ms", bus.react_ms, s.exp_ms);
    chk("busy_drop", bus.busy, 0);
    step(0, 0, 0, 0);
    chk("react_valid_one_cycle", bus.react_valid, 0);
  endtask

  initial begin
    bit btn;
    build_seq();
    bus.tick = 0; bus.cmd_delay = 0; bus.button = 0;
    scen[0] = '{pre: 2, hold: 4,  react: 25,  exp_ms: 25};
    scen[1] = '{pre: 0, hold: 1,  react: 0,   exp_ms: 0};
    scen[2] = '{pre: 6, hold: 65, react: 3,   exp_ms: 3};
    scen[3] = '{pre: 3, hold: 8,  react: 100, exp_ms: 100};

    step(1, 0, 0, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_react_ms", bus.react_ms, 0);

    foreach (scen[i]) run_scen(scen[i]);

    // false start before the final tick
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (2) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
    step(0, 0, 0, 1);
    chk("false_start", bus.false_start, 1);
    chk("fs_busy", bus.busy, 0);
    repeat (4) step(0, 1, 0, 0);
    chk("no_time_out_after_fs", bus.time_out, 0);

    // press coincident with the final tick
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("fs_coincident", bus.false_start, 1);
    chk("to_suppressed", bus.time_out, 0);

    // saturation with no response
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    chk("sat_time_out", bus.time_out, 1);
    repeat (RMAX) step(0, 1, 0, 0);
    chk("sat_not_yet", bus.react_valid, 0);
    step(0, 1, 0, 0);
    chk("sat_valid", bus.react_valid, 1);
    chk("sat_ms", bus.react_ms, RMAX);
    chk("sat_idle", bus.busy, 0);

    // held button never false-starts; stray cmd_delay ignored
    step(1, 0, 0, 1);
    repeat (2) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (3) begin step(0, 1, 0, 1); step(0, 0, 1, 1); end
    step(0, 1, 0, 1);
    chk("held_time_out", bus.time_out, 1);
    step(0, 0, 0, 0);
    repeat (5) begin step(0, 1, 0, 0); step(0, 0, 1, 0); end
    step(0, 0, 0, 1);
    chk("held_valid", bus.react_valid, 1);
    chk("held_ms", bus.react_ms, 5);
    step(0, 0, 0, 0);

    // reset mid-REACT after a prior result
    step(0, 0, 1, 0);
    for (int k = 0; k < 200 && !bus.time_out; k++) step(0, 1, 0, 0);
    chk("rst_reach_react", bus.time_out, 1);
    repeat (2) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_ms_cleared", bus.react_ms, 0);
    chk("rst_no_valid", bus.react_valid, 0);
    chk("rst_idle", bus.busy, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    chk("rst_lfsr_01", bus.time_out, 1);

    // random traffic against the reference
    btn = 0;
    for (int k = 0; k < 8000; k++) begin
      if ($urandom_range(39) == 0) btn = ~btn;
      step(($urandom_range(999) == 0), ($urandom_range(3) == 0),
           ($urandom_range(19) == 0), btn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
